// File: rtl/mem_arb_pkg.sv
// Shared types for the instruction/data memory port arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } arb_state_e;

  typedef enum logic {
    OWNER_INSTR = 1'b0,
    OWNER_DATA  = 1'b1
  } owner_e;

endpackage

// File: rtl/mem_port_arbiter.sv
// Arbitrates an instruction-fetch port and a load/store port onto one memory port,
// one transaction at a time. ARB_ROUND_ROBIN_EN selects round-robin over fixed data priority.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,

  input  logic                    instr_req_i,
  input  logic [ADDR_WIDTH-1:0]   instr_addr_i,
  output logic                    instr_gnt_o,
  output logic                    instr_rvalid_o,
  output logic [DATA_WIDTH-1:0]   instr_rdata_o,

  input  logic                    data_req_i,
  input  logic                    data_we_i,
  input  logic [DATA_WIDTH/8-1:0] data_be_i,
  input  logic [ADDR_WIDTH-1:0]   data_addr_i,
  input  logic [DATA_WIDTH-1:0]   data_wdata_i,
  output logic                    data_gnt_o,
  output logic                    data_rvalid_o,
  output logic [DATA_WIDTH-1:0]   data_rdata_o,

  output logic                    mem_req_o,
  output logic                    mem_we_o,
  output logic [DATA_WIDTH/8-1:0] mem_be_o,
  output logic [ADDR_WIDTH-1:0]   mem_addr_o,
  output logic [DATA_WIDTH-1:0]   mem_wdata_o,
  input  logic                    mem_gnt_i,
  input  logic                    mem_rvalid_i,
  input  logic [DATA_WIDTH-1:0]   mem_rdata_i
);

  localparam int BE_WIDTH = DATA_WIDTH / 8;

  arb_state_e            state_q, state_d;
  owner_e                owner_q, owner_d;
  logic                  we_q, we_d;
  logic [BE_WIDTH-1:0]   be_q, be_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  owner_e                pick;

`ifdef ARB_ROUND_ROBIN_EN
  owner_e last_q, last_d;
`endif

  always_comb begin
    pick = OWNER_INSTR;
    if (instr_req_i && data_req_i) begin
`ifdef ARB_ROUND_ROBIN_EN
      pick = (last_q == OWNER_DATA) ? OWNER_INSTR : OWNER_DATA;
`else
      pick = OWNER_DATA;
`endif
    end else if (data_req_i) begin
      pick = OWNER_DATA;
    end
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    we_d    = we_q;
    be_d    = be_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
`ifdef ARB_ROUND_ROBIN_EN
    last_d  = last_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (instr_req_i || data_req_i) begin
          state_d = REQ;
          owner_d = pick;
          if (pick == OWNER_DATA) begin
            we_d    = data_we_i;
            be_d    = data_be_i;
            addr_d  = data_addr_i;
            wdata_d = data_wdata_i;
          end else begin
            // Fetches are presented to memory as full-word loads.
            we_d    = 1'b0;
            be_d    = '1;
            addr_d  = instr_addr_i;
            wdata_d = '0;
          end
        end
      end
      REQ: begin
        if (mem_gnt_i) state_d = RESP;
      end
      RESP: begin
        if (mem_rvalid_i) begin
          state_d = IDLE;
`ifdef ARB_ROUND_ROBIN_EN
          last_d  = owner_q;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      owner_q <= OWNER_INSTR;
      we_q    <= 1'b0;
      be_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
`ifdef ARB_ROUND_ROBIN_EN
      last_q  <= OWNER_INSTR;
`endif
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      we_q    <= we_d;
      be_q    <= be_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
`ifdef ARB_ROUND_ROBIN_EN
      last_q  <= last_d;
`endif
    end
  end

  logic in_req;
  logic resp_hit;

  // Memory strobes outside their own phase are ignored by gating on state.
  always_comb begin
    in_req         = (state_q == REQ);
    resp_hit       = (state_q == RESP) && mem_rvalid_i;

    mem_req_o      = in_req;
    mem_we_o       = in_req && we_q;
    mem_be_o       = in_req ? be_q    : '0;
    mem_addr_o     = in_req ? addr_q  : '0;
    mem_wdata_o    = in_req ? wdata_q : '0;

    instr_gnt_o    = in_req && mem_gnt_i && (owner_q == OWNER_INSTR);
    data_gnt_o     = in_req && mem_gnt_i && (owner_q == OWNER_DATA);

    instr_rvalid_o = resp_hit && (owner_q == OWNER_INSTR);
    data_rvalid_o  = resp_hit && (owner_q == OWNER_DATA);

    instr_rdata_o  = instr_rvalid_o ? mem_rdata_i : '0;
    data_rdata_o   = (data_rvalid_o && !we_q) ? mem_rdata_i : '0;
  end

endmodule
